// File: rtl/sipo_comma_align_if.sv
// Receive-side bundle for the comma-aligning deserializer: serial bit in,
// aligned word plus status out.
interface sipo_comma_align_if;
  logic       Serial;
  logic [9:0] RxParallel_10;
  logic       RxValid;
  logic       CommaDet;
  logic       Locked;
  logic       AlignErr;

  modport master (
    output Serial,
    input  RxParallel_10,
    input  RxValid,
    input  CommaDet,
    input  Locked,
    input  AlignErr
  );

  modport slave (
    input  Serial,
    output RxParallel_10,
    output RxValid,
    output CommaDet,
    output Locked,
    output AlignErr
  );
endinterface

// File: rtl/sipo_comma_align.sv
// Serial-to-parallel receiver that finds K28.5 commas in the bit stream,
// frames 10-bit words on them and declares lock after LOCK_CNT aligned commas.
module sipo_comma_align #(
  parameter int unsigned LOCK_CNT = 3,
  parameter logic [9:0]  COMMA_P  = 10'b0011111010,
  parameter logic [9:0]  COMMA_N  = 10'b1100000101
) (
  input  logic              BitCLK,
  input  logic              Reset,
  sipo_comma_align_if.slave bus
);

  localparam int unsigned CW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [9:0]      shreg_q, shreg_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [9:0]      rx_word_q, rx_word_d;
  logic            rx_valid_q, rx_valid_d;
  logic            comma_det_q, comma_det_d;
  logic            align_err_q, align_err_d;

  logic [9:0]      win;
  logic            hit;
  logic            boundary;
  logic            realign;
  logic            emit;
  logic [CW-1:0]   cnt_inc;

  // The window includes the bit being sampled, so a word is recognised on
  // the same edge that captures its last bit.
  always_comb begin
    win      = {shreg_q[8:0], bus.Serial};
    shreg_d  = win;
    hit      = (win == COMMA_P) || (win == COMMA_N);
    boundary = (bit_cnt_q == 4'd9);
    cnt_inc  = cnt_q + CW'(1);
  end

  always_ff @(posedge BitCLK or negedge Reset) begin
    if (!Reset) begin
      state_q     <= HUNT;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      cnt_q       <= '0;
      rx_word_q   <= '0;
      rx_valid_q  <= 1'b0;
      comma_det_q <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      cnt_q       <= cnt_d;
      rx_word_q   <= rx_word_d;
      rx_valid_q  <= rx_valid_d;
      comma_det_q <= comma_det_d;
      align_err_q <= align_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      HUNT: begin
        if (hit) begin
          cnt_d   = CW'(1);
          state_d = (LOCK_CNT <= 1) ? LOCKED : CONFIRM;
        end
      end
      CONFIRM: begin
        if (hit && !boundary) begin
          cnt_d   = CW'(1);
          state_d = CONFIRM;
        end else if (hit && boundary) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CW'(LOCK_CNT)) begin
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (hit && !boundary) begin
          cnt_d   = CW'(1);
          state_d = CONFIRM;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = HUNT;
      end
    endcase
  end

  // In HUNT every comma is a realignment; once framed only an off-boundary
  // comma is, and that is the case flagged as an alignment error.
  always_comb begin
    realign     = hit && ((state_q == HUNT) || !boundary);
    emit        = realign || ((state_q != HUNT) && boundary);
    bit_cnt_d   = (realign || boundary) ? 4'd0 : bit_cnt_q + 4'd1;
    rx_valid_d  = emit;
    rx_word_d   = emit ? win : rx_word_q;
    comma_det_d = emit && hit;
    align_err_d = hit && (state_q != HUNT) && !boundary;
  end

  assign bus.RxParallel_10 = rx_word_q;
  assign bus.RxValid       = rx_valid_q;
  assign bus.CommaDet      = comma_det_q;
  assign bus.AlignErr      = align_err_q;
  assign bus.Locked        = (state_q == LOCKED);

endmodule
